// File: rtl/npu_pkg.sv
// Shared constants and types for the systolic array result path.
package npu_pkg;

  localparam int N       = 10;
  localparam int IN_W    = 16;
  localparam int OUT_W   = 8;
  localparam int IDX_W   = 4;
  localparam int SHIFT_W = 4;
  localparam int ELEM_W  = $clog2(N * N);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    FINISH
  } drain_state_t;

  typedef logic signed [IN_W-1:0]  res_t;
  typedef logic signed [OUT_W-1:0] out_t;
  typedef logic [IDX_W-1:0]        idx_t;

endpackage

// File: rtl/result_drain_if.sv
// Valid/ready element stream from the result drain to the writeback stage.
interface result_drain_if;
  import npu_pkg::*;

  logic out_valid;
  logic out_ready;
  out_t out_data;
  idx_t out_row;
  idx_t out_col;
  logic out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
    output out_ready
  );

endinterface

// File: rtl/requant_unit.sv
// Combinational requantizer: arithmetic right shift, optional ReLU, signed saturation.
module requant_unit
  import npu_pkg::*;
(
  input  res_t               x,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               relu,
  output out_t               y,
  output logic               sat_flag
);

  localparam logic [SHIFT_W:0] MAX_SHIFT = (SHIFT_W+1)'(IN_W - 1);
  localparam res_t SAT_HI = res_t'((1 <<< (OUT_W - 1)) - 1);
  localparam res_t SAT_LO = res_t'(-(1 <<< (OUT_W - 1)));

  logic [SHIFT_W:0] shift_ext;
  logic [SHIFT_W:0] shift_eff;
  res_t             s;

  // NOTE: every always_comb output gets a default before any branch; a path that
  // leaves a variable unassigned would infer a latch.
  always_comb begin
    shift_ext = {1'b0, shift};
    shift_eff = (shift_ext > MAX_SHIFT) ? MAX_SHIFT : shift_ext;
    s         = x >>> shift_eff;
    if (relu && (s < 0)) begin
      s = '0;
    end
    y        = s[OUT_W-1:0];
    sat_flag = 1'b0;
    if (s > SAT_HI) begin
      y        = SAT_HI[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (s < SAT_LO) begin
      y        = SAT_LO[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

endmodule

// File: rtl/result_drain.sv
// Snapshots the array result matrix on capture and streams requantized
// elements in row-major order, one per cycle while the consumer is ready.
module result_drain
  import npu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_valid,
  input  logic [N*N*IN_W-1:0]   res_in,
  input  logic [SHIFT_W-1:0]    cfg_shift,
  input  logic                  cfg_relu,
  output logic                  busy,
  output logic                  drain_done,
  output logic [7:0]            sat_count,
  result_drain_if.master        drain
);

  drain_state_t state_q, state_d;

  logic [N*N-1:0][IN_W-1:0] buf_q;
  logic [SHIFT_W-1:0]       shift_q;
  logic                     relu_q;

  idx_t  row_q, col_q;
  idx_t  sel_row, sel_col;
  logic  [ELEM_W-1:0] sel_elem;
  logic  valid_q, last_q;
  out_t  data_q;

  logic  capture, load, xfer;
  out_t  rq_data;
  logic  rq_sat;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    load    = 1'b0;
    sel_row = '0;
    sel_col = '0;
    xfer    = valid_q && drain.out_ready;
    case (state_q)
      IDLE: begin
        if (cap_valid) begin
          capture = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          if (last_q) begin
            state_d = FINISH;
          end else begin
            // Prefetch the following element so a transfer never leaves a bubble.
            load = 1'b1;
            if (col_q == idx_t'(N - 1)) begin
              sel_row = row_q + 1'b1;
            end else begin
              sel_row = row_q;
              sel_col = col_q + 1'b1;
            end
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_elem = ELEM_W'(sel_row) * ELEM_W'(N) + ELEM_W'(sel_col);

  requant_unit u_requant (
    .x        (buf_q[sel_elem]),
    .shift    (shift_q),
    .relu     (relu_q),
    .y        (rq_data),
    .sat_flag (rq_sat)
  );

  // NOTE: the snapshot buffer is deliberately left out of reset; it is always
  // written on capture before any element is read, so a reset would be pure cost.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q <= res_in;
    end
  end

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      sat_count <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        shift_q   <= cfg_shift;
        relu_q    <= cfg_relu;
        sat_count <= '0;
        busy      <= 1'b1;
      end
      if (load) begin
        data_q  <= rq_data;
        row_q   <= sel_row;
        col_q   <= sel_col;
        last_q  <= (sel_row == idx_t'(N - 1)) && (sel_col == idx_t'(N - 1));
        valid_q <= 1'b1;
        if (rq_sat && (sat_count != 8'hFF)) begin
          sat_count <= sat_count + 8'd1;
        end
      end else if (xfer && last_q) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy    <= 1'b0;
      end
    end
  end

  assign drain_done      = (state_q == FINISH);
  assign drain.out_valid = valid_q;
  assign drain.out_data  = data_q;
  assign drain.out_row   = row_q;
  assign drain.out_col   = col_q;
  assign drain.out_last  = last_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: single-element vector table plus
// ramp, saturation, backpressure, ignored-capture and mid-drain reset sequences.
module tb_result_drain;
  import npu_pkg::*;

  typedef logic [N*N*IN_W-1:0] mat_t;

  typedef struct {
    int r;
    int c;
    int x;
    int sh;
    bit relu;
    int exp;
    int sat;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             cap_valid;
  mat_t             res_in;
  logic [SHIFT_W-1:0] cfg_shift;
  logic             cfg_relu;
  logic             busy;
  logic             drain_done;
  logic [7:0]       sat_count;

  result_drain_if stream ();

  result_drain dut (
    .clk        (clk),
    .rst        (rst),
    .cap_valid  (cap_valid),
    .res_in     (res_in),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .busy       (busy),
    .drain_done (drain_done),
    .sat_count  (sat_count),
    .drain      (stream)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  int bd[128];
  int br[128];
  int bc[128];
  int nbeats, first_valid, done_cyc, last_cnt, last_at, stall_bad;
  int busy_at1, busy_done, busy_after, dd_after, snap_row, snap_col;
  mat_t ramp_mat, alt_mat, sat_mat, m;
  vec_t vecs[10];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic mat_t put(input mat_t mi, input int r, input int c, input int v);
    mat_t t;
    t = mi;
    t[(r*N+c)*IN_W +: IN_W] = IN_W'(v);
    return t;
  endfunction

  function automatic int order_errs();
    int e;
    e = 0;
    for (int k = 0; k < N*N; k++) begin
      if (br[k] != k / N || bc[k] != k % N) e++;
    end
    return e;
  endfunction

  function automatic int ramp_errs();
    int e;
    e = 0;
    for (int k = 0; k < N*N; k++) begin
      if (bd[k] != k) e++;
    end
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge of cycle t+1.
  task automatic do_capture(input mat_t mi, input int sh, input bit relu);
    res_in    = mi;
    cfg_shift = SHIFT_W'(sh);
    cfg_relu  = relu;
    cap_valid = 1'b1;
    @(negedge clk);
    cap_valid = 1'b0;
    res_in    = alt_mat;
    cfg_shift = 4'd7;
    cfg_relu  = ~relu;
  endtask

  // Cycle numbering: cyc=1 is t+1 (the LOAD cycle).
  task automatic drain(input int stall_lo, input int stall_hi, input int inj_cyc,
                       input int stop_beats);
    bit   snapped;
    int   snap_d, snap_l;
    snapped = 1'b0;
    snap_d = 0;
    snap_l = 0;
    nbeats = 0; first_valid = -1; done_cyc = -1; last_cnt = 0; last_at = -1;
    stall_bad = 0; busy_at1 = -1; busy_done = -1; busy_after = -1; dd_after = -1;
    snap_row = -1; snap_col = -1;
    for (int k = 0; k < 128; k++) begin
      bd[k] = -999; br[k] = -1; bc[k] = -1;
    end
    for (int cyc = 1; cyc <= 400; cyc++) begin
      stream.out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      cap_valid = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin
        res_in = alt_mat; cfg_shift = 4'd3; cfg_relu = 1'b1;
      end
      if (cyc == 1) busy_at1 = int'(busy);
      if (stream.out_valid && first_valid < 0) first_valid = cyc;
      if (cyc >= stall_lo && cyc <= stall_hi) begin
        if (!stream.out_valid) stall_bad++;
        if (!snapped) begin
          snapped  = 1'b1;
          snap_d   = int'(stream.out_data);
          snap_l   = int'(stream.out_last);
          snap_row = int'(stream.out_row);
          snap_col = int'(stream.out_col);
        end else if (int'(stream.out_data) != snap_d || int'(stream.out_last) != snap_l ||
                     int'(stream.out_row) != snap_row || int'(stream.out_col) != snap_col) begin
          stall_bad++;
        end
      end
      if (stream.out_valid && stream.out_ready) begin
        if (nbeats < 128) begin
          bd[nbeats] = int'(stream.out_data);
          br[nbeats] = int'(stream.out_row);
          bc[nbeats] = int'(stream.out_col);
        end
        if (stream.out_last) begin
          last_cnt++;
          last_at = nbeats;
        end
        nbeats++;
        if (stop_beats > 0 && nbeats == stop_beats) return;
      end
      if (drain_done && done_cyc < 0) begin
        done_cyc  = cyc;
        busy_done = int'(busy);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = int'(busy);
        dd_after   = int'(drain_done);
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    cap_valid = 1'b0;
    cfg_shift = '0;
    cfg_relu = 1'b0;
    res_in = '0;
    stream.out_ready = 1'b0;

    ramp_mat = '0;
    alt_mat  = '0;
    sat_mat  = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        ramp_mat = put(ramp_mat, r, c, r*10 + c);
        alt_mat  = put(alt_mat, r, c, 5000);
        sat_mat  = put(sat_mat, r, c, (r + c) % 5 - 2);
      end
    end
    sat_mat = put(sat_mat, 2, 3, 5000);
    sat_mat = put(sat_mat, 2, 4, -5000);

    //          r  c      x  sh relu exp  sat
    vecs[0] = '{0, 0,    100,  2, 0,   25, 0};
    vecs[1] = '{0, 1,     -7,  1, 0,   -4, 0};
    vecs[2] = '{0, 1,     -7,  1, 1,    0, 0};
    vecs[3] = '{2, 3,   5000,  0, 0,  127, 1};
    vecs[4] = '{2, 4,  -5000,  0, 0, -128, 1};
    vecs[5] = '{5, 5,     -1, 15, 0,   -1, 0};
    vecs[6] = '{9, 9,  32767,  8, 0,  127, 0};
    vecs[7] = '{3, 7, -32768,  8, 0, -128, 0};
    vecs[8] = '{4, 2,    256,  1, 0,  127, 1};
    vecs[9] = '{1, 1,   -129,  0, 1,    0, 0};

    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset out_valid", int'(stream.out_valid), 0);
    check("reset out_last", int'(stream.out_last), 0);
    check("reset drain_done", int'(drain_done), 0);
    check("reset out_data", int'(stream.out_data), 0);
    check("reset sat_count", int'(sat_count), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      int others;
      m = put('0, vecs[i].r, vecs[i].c, vecs[i].x);
      do_capture(m, vecs[i].sh, vecs[i].relu);
      drain(-1, -1, -1, 0);
      others = 0;
      for (int k = 0; k < N*N; k++) begin
        if (k != vecs[i].r*N + vecs[i].c && bd[k] != 0) others++;
      end
      check($sformatf("vec%0d data", i), bd[vecs[i].r*N + vecs[i].c], vecs[i].exp);
      check($sformatf("vec%0d other elems", i), others, 0);
      check($sformatf("vec%0d beats", i), nbeats, 100);
      check($sformatf("vec%0d order", i), order_errs(), 0);
      check($sformatf("vec%0d sat_count", i), int'(sat_count), vecs[i].sat);
      check($sformatf("vec%0d first valid cycle", i), first_valid, 2);
      check($sformatf("vec%0d done cycle", i), done_cyc, 102);
    end

    // Full ramp with out_ready held high.
    do_capture(ramp_mat, 0, 1'b0);
    drain(-1, -1, -1, 0);
    check("ramp busy in LOAD", busy_at1, 1);
    check("ramp data", ramp_errs(), 0);
    check("ramp order", order_errs(), 0);
    check("ramp beats", nbeats, 100);
    check("ramp last count", last_cnt, 1);
    check("ramp last index", last_at, 99);
    check("ramp done cycle", done_cyc, 102);
    check("ramp busy at done", busy_done, 0);
    check("ramp busy after", busy_after, 0);
    check("ramp done pulse width", dd_after, 0);

    // Two clamped elements among small values.
    do_capture(sat_mat, 0, 1'b0);
    drain(-1, -1, -1, 0);
    begin
      int e;
      e = 0;
      for (int k = 0; k < N*N; k++) begin
        if (k != 23 && k != 24 && bd[k] != (k / N + k % N) % 5 - 2) e++;
      end
      check("sat small elems", e, 0);
    end
    check("sat pos clamp", bd[23], 127);
    check("sat neg clamp", bd[24], -128);
    check("sat_count after drain", int'(sat_count), 2);
    repeat (3) @(negedge clk);
    check("sat_count held", int'(sat_count), 2);

    // Backpressure over cycles t+4..t+8.
    do_capture(ramp_mat, 0, 1'b0);
    check("capture clears sat_count", int'(sat_count), 0);
    drain(4, 8, -1, 0);
    check("stall held stable", stall_bad, 0);
    check("stall row", snap_row, 0);
    check("stall col", snap_col, 2);
    check("stall data", ramp_errs(), 0);
    check("stall order", order_errs(), 0);
    check("stall beats", nbeats, 100);
    check("stall done cycle", done_cyc, 107);

    // Capture request mid-stream must be ignored.
    do_capture(ramp_mat, 0, 1'b0);
    drain(-1, -1, 20, 0);
    check("ignored cap data", ramp_errs(), 0);
    check("ignored cap beats", nbeats, 100);
    check("ignored cap sat_count", int'(sat_count), 0);
    check("ignored cap done cycle", done_cyc, 102);

    // Reset while beat 37 is presented, then a fresh capture.
    do_capture(ramp_mat, 0, 1'b0);
    drain(-1, -1, -1, 37);
    check("pre-reset beats", nbeats, 37);
    rst = 1'b0;
    #1;
    check("mid reset out_valid", int'(stream.out_valid), 0);
    check("mid reset busy", int'(busy), 0);
    check("mid reset out_row", int'(stream.out_row), 0);
    check("mid reset out_col", int'(stream.out_col), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post reset out_valid", int'(stream.out_valid), 0);
    do_capture(ramp_mat, 0, 1'b0);
    drain(-1, -1, -1, 0);
    check("restart first row", br[0], 0);
    check("restart first col", bc[0], 0);
    check("restart data", ramp_errs(), 0);
    check("restart beats", nbeats, 100);
    check("restart done cycle", done_cyc, 102);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream stage of the 10x10 weight-stationary systolic array.
- On the array's done pulse, snapshots the full 16-bit signed result matrix.
- Requantizes each element: arithmetic shift, optional ReLU, saturation to OUT_W.
- Streams elements out in row-major order over a valid/ready interface to the writeback/memory stage, then pulses drain_done.

Parameters:
N, 10, matrix dimension (rows = cols)
IN_W, 16, signed width of incoming results
OUT_W, 8, signed width of streamed output
IDX_W, 4, width of row/col indices (must be at least clog2(N))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cap_valid  input  1  capture request (driven by array done)
res_in  input  N*N*IN_W  signed result matrix [row][col]
cfg_shift  input  4  right-shift amount, sampled at capture
cfg_relu  input  1  ReLU enable, sampled at capture
busy  output  1  high from capture through final transfer
out_valid  output  1  out_data holds a valid element
out_ready  input  1  consumer accepts element
out_data  output  OUT_W  signed requantized element
out_row  output  IDX_W  row index of out_data
out_col  output  IDX_W  column index of out_data
out_last  output  1  high with element (N-1,N-1)
drain_done  output  1  one-cycle pulse after last transfer
sat_count  output  8  elements saturated in current drain

Behaviour:
- Reset (rst=0, async): state IDLE; busy, out_valid, out_last, drain_done = 0; out_data, out_row, out_col, sat_count = 0. Buffer contents are don't-care.
- FSM states: IDLE, LOAD, STREAM, FINISH.
- IDLE:
  - cap_valid=1 in cycle t registers res_in into the buffer, latches cfg_shift and cfg_relu, clears sat_count, sets busy, and goes to LOAD.
- LOAD (cycle t+1):
  - Requantizes element (0,0) into the output register, sets out_valid=1, and goes to STREAM.
  - First out_valid is therefore visible at t+2.
- STREAM:
  - A transfer occurs when out_valid and out_ready are both 1.
  - On a transfer, col increments; at col=N-1, col wraps to 0 and row increments.
  - The next element is loaded into the output register in the same edge, so there are no bubbles: one element per cycle while out_ready stays high.
  - When out_ready=0, out_data, out_row, out_col and out_last hold stable and out_valid stays 1.
  - out_last=1 exactly when the index is (N-1,N-1).
  - The transfer of the last element clears out_valid and busy and enters FINISH.
- FINISH:
  - drain_done=1 for one cycle, then IDLE.
  - With out_ready held high, drain_done is high at cycle t+2+N*N.
- cap_valid outside IDLE is ignored; the buffer and config are not disturbed.
- cap_valid in the FINISH cycle is also ignored. The upstream array holds done, so the request is re-sampled in IDLE.
- Requant arithmetic, per element x:
  - s = x >>> cfg_shift (arithmetic, rounds toward -inf).
  - If cfg_relu=1 and s<0, then s=0.
  - Saturate s to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - cfg_shift greater than IN_W-1 behaves as IN_W-1.
- sat_count increments, saturating at 255, each time a clamped element is loaded into the output register. It is held after drain until the next capture.
- Reset asserted mid-drain: outputs return to reset values immediately and the partial stream is abandoned. The next capture restarts at (0,0).

Decomposition:
- npu_pkg: N, IN_W, OUT_W, IDX_W constants and the drain_state_t enum (IDLE, LOAD, STREAM, FINISH).
- Sub-module requant_unit: purely combinational shift, ReLU and saturation, with a sat_flag output. It is instantiated once, on the buffer element selected by the next index.

Test Plan:
- Single element check: res_in[0][0]=100, shift=2, relu=0, out_ready=1 → first beat out_data=25, row=0, col=0, out_valid rises at t+2.
- Negative input: res_in[0][1]=-7, shift=1 → out_data=-4 with relu=0; out_data=0 with relu=1.
- Saturation: res_in[2][3]=5000, res_in[2][4]=-5000, shift=0 → out_data 127 and -128; sat_count=2 after drain; all other elements small.
- Backpressure: out_ready=0 for cycles t+4..t+8 → beat (0,2) held stable with out_valid=1; no element skipped or duplicated; 100 beats total.
- Full ramp: res_in[r][c]=r*10+c, shift=0 → data 0..99 in row-major order; out_last only on beat 100; drain_done at t+102; busy low afterward.
- Ignored capture and reset: pulse cap_valid mid-stream with a new matrix → the stream is unchanged. Assert rst=0 at beat 37 → out_valid drops immediately. A new capture then restarts the stream at (0,0).
